buffered_uart: RTL and testbench

Byte-oriented full-duplex UART (8N1) with an RX FIFO and a TX FIFO, giving a host a parallel push/pop interface to a serial line. Host writes bytes into the TX FIFO, and the block serialises them on `tx`. Bytes received on `rx` are deserialised into the RX FIFO for the host to read. It sits between a CPU/bus-side register port and the board's serial pins.

---
 rtl/buffered_uart_pkg.sv | 23 ++
 rtl/buffered_uart_if.sv | 21 ++
 rtl/fifo.sv | 43 ++++
 rtl/buffered_uart.sv | 180 ++++++++++++++++++
 tb/tb_buffered_uart.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/buffered_uart_pkg.sv
// Shared frame constants and serialiser state encodings for buffered_uart.
package buffered_uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/buffered_uart_if.sv
// Host-side byte port of buffered_uart: active-low strobes, FIFO status and data.
interface buffered_uart_if;

    logic [7:0] data_in;
    logic       nwr;
    logic [7:0] data_out;
    logic       nrd;
    logic       full;
    logic       empty;

    modport master (
        output data_in, nwr, nrd,
        input  data_out, full, empty
    );

    modport slave (
        input  data_in, nwr, nrd,
        output data_out, full, empty
    );

endinterface

// File: rtl/fifo.sv
// Circular-buffer FIFO with wrap-bit pointers and first-word fall-through output.
module fifo #(
    parameter int WIDTH     = 8,
    parameter int SIZE_BITS = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2**SIZE_BITS];
    logic [SIZE_BITS:0] wptr_q;
    logic [SIZE_BITS:0] rptr_q;
    logic do_push;
    logic do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[SIZE_BITS] != rptr_q[SIZE_BITS]) &&
                     (wptr_q[SIZE_BITS-1:0] == rptr_q[SIZE_BITS-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q[SIZE_BITS-1:0]];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[SIZE_BITS-1:0]] <= din_i;
    end

endmodule

// File: rtl/buffered_uart.sv
// 8N1 full-duplex UART with TX/RX FIFOs behind an edge-strobed host byte port.
module buffered_uart
    import buffered_uart_pkg::*;
#(
    parameter int RX_FIFO_BITS       = 7,
    parameter int TX_FIFO_BITS       = 7,
    parameter int CLOCK_DIV          = 234,
    parameter int CLOCK_COUNTER_BITS = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic rx,
    output logic tx,
    buffered_uart_if.slave bus
);

    localparam logic [CLOCK_COUNTER_BITS-1:0] BIT_LAST  = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] HALF_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);
    localparam logic [2:0]                    LAST_BIT  = 3'(DATA_BITS - 1);

    logic nwr_q, nrd_q, wr_stb, rd_stb;
    logic [7:0] tx_head, rx_head;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, rx_push;

    tx_state_t tx_state_q, tx_state_d;
    logic [CLOCK_COUNTER_BITS-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic tx_q, tx_d;

    rx_state_t rx_state_q, rx_state_d;
    logic [CLOCK_COUNTER_BITS-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    assign wr_stb       = nwr_q & ~bus.nwr;
    assign rd_stb       = nrd_q & ~bus.nrd;
    assign bus.full     = tx_full;
    assign bus.empty    = rx_empty;
    assign bus.data_out = rx_head;
    assign tx           = tx_q;

    fifo #(.WIDTH(8), .SIZE_BITS(TX_FIFO_BITS)) u_tx_fifo (
        .clk(clk), .nreset(nreset),
        .push_i(wr_stb), .din_i(bus.data_in), .pop_i(tx_pop),
        .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    fifo #(.WIDTH(8), .SIZE_BITS(RX_FIFO_BITS)) u_rx_fifo (
        .clk(clk), .nreset(nreset),
        .push_i(rx_push), .din_i(rx_shift_q), .pop_i(rd_stb),
        .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nwr_q      <= 1'b1;
            nrd_q      <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            nwr_q      <= bus.nwr;
            nrd_q      <= bus.nrd;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // STOP reloads straight into START when more data is queued, keeping frames back-to-back.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: if (!tx_empty) tx_state_d = TX_LOAD;
            TX_LOAD: begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
                    else tx_bit_d = tx_bit_q + 1'b1;
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TX_START;
                    end else tx_state_d = TX_IDLE;
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        unique case (tx_state_d)
            TX_START: tx_d = START_BIT;
            TX_DATA:  tx_d = tx_shift_d[0];
            TX_STOP:  tx_d = STOP_BIT;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = (rx_sync_q == START_BIT) ? RX_DATA : RX_IDLE;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
                    else rx_bit_d = rx_bit_q + 1'b1;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = (rx_sync_q == STOP_BIT) && !rx_full;
                    rx_state_d = RX_IDLE;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_buffered_uart.sv
// Scoreboard bench for buffered_uart: loopback, FIFO fill, RX error injection, reset, held strobe.
module tb_buffered_uart;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic tx;
    logic rx_line;
    logic loop_en = 1'b1;
    logic inj_rx = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    buffered_uart_if bus ();

    assign rx_line = loop_en ? tx : inj_rx;

    buffered_uart #(
        .RX_FIFO_BITS(5),
        .TX_FIFO_BITS(4),
        .CLOCK_DIV(8),
        .CLOCK_COUNTER_BITS(4)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .rx(rx_line),
        .tx(tx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] b, input bit accept);
        @(negedge clk);
        bus.data_in = b;
        bus.nwr = 1'b0;
        @(negedge clk);
        bus.nwr = 1'b1;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic host_read();
        @(negedge clk);
        bus.nrd = 1'b0;
        @(negedge clk);
        bus.nrd = 1'b1;
    endtask

    task automatic wait_nonempty(input int timeout);
        int n;
        n = 0;
        while (bus.empty && n < timeout) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv_check(input string tag, input int timeout);
        logic [7:0] e;
        wait_nonempty(timeout);
        check_eq({tag, "_arrive"}, bus.empty, 0);
        e = 8'h00;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_eq({tag, "_data"}, bus.data_out, e);
        host_read();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            inj_rx = fr[i];
            repeat (8) @(negedge clk);
        end
        inj_rx = 1'b1;
    endtask

    initial begin
        logic [9:0] fr;
        int n;
        bus.data_in = 8'h00;
        bus.nwr = 1'b1;
        bus.nrd = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_dout", bus.data_out, 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // loopback 0x5A with bit-level frame check
        fr = {1'b1, 8'h5A, 1'b0};
        @(negedge clk);
        bus.data_in = 8'h5A;
        bus.nwr = 1'b0;
        exp_q.push_back(8'h5A);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus.nwr = 1'b1;
            n = i;
            if (tx == 1'b0) break;
        end
        check_eq("start_within_3", (n <= 3) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) repeat (8) @(negedge clk);
            check_eq($sformatf("tx_bit%0d", i), tx, fr[i]);
        end
        wait_nonempty(30);
        check_eq("lb1_arrive", bus.empty, 0);
        check_eq("lb1_data", bus.data_out, exp_q.pop_front());

        // simultaneous pop of 0x5A and write of 0xA5
        @(negedge clk);
        bus.nrd = 1'b0;
        bus.nwr = 1'b0;
        bus.data_in = 8'hA5;
        @(negedge clk);
        bus.nrd = 1'b1;
        bus.nwr = 1'b1;
        exp_q.push_back(8'hA5);
        check_eq("pop_empty", bus.empty, 1);
        recv_check("lb2", 200);
        check_eq("lb2_empty", bus.empty, 1);

        // TX FIFO fill while a frame is in flight
        host_write(8'h10, 1'b1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            host_write(8'(8'h20 + i), i < 16);
            if (i == 14) check_eq("full_before", bus.full, 0);
            if (i == 15) check_eq("full_at16", bus.full, 1);
        end
        check_eq("full_extra", bus.full, 1);
        for (int i = 0; i < 17; i++) recv_check($sformatf("fill%0d", i), 200);
        check_eq("fill_empty", bus.empty, 1);
        check_eq("fill_notfull", bus.full, 0);

        // RX framing error, glitch, then a good injected frame
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        send_frame(8'h81, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("framing_drop", bus.empty, 1);
        inj_rx = 1'b0;
        repeat (2) @(negedge clk);
        inj_rx = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("glitch_drop", bus.empty, 1);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        recv_check("inject", 40);

        // reset mid-frame with a byte waiting in the RX FIFO
        repeat (10) @(negedge clk);
        loop_en = 1'b1;
        host_write(8'h77, 1'b0);
        wait_nonempty(120);
        check_eq("pre_rst_data", bus.data_out, 8'h77);
        host_write(8'h88, 1'b0);
        host_write(8'h99, 1'b0);
        repeat (30) @(negedge clk);
        nreset = 1'b0;
        #1;
        check_eq("midrst_tx", tx, 1);
        check_eq("midrst_empty", bus.empty, 1);
        check_eq("midrst_full", bus.full, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        host_write(8'hC3, 1'b1);
        recv_check("post_rst", 120);
        repeat (100) @(negedge clk);
        check_eq("post_rst_idle", bus.empty, 1);

        // nwr held low for 10 clocks queues one byte
        @(negedge clk);
        bus.data_in = 8'h96;
        bus.nwr = 1'b0;
        exp_q.push_back(8'h96);
        repeat (10) @(negedge clk);
        bus.nwr = 1'b1;
        recv_check("hold", 120);
        repeat (200) @(negedge clk);
        check_eq("hold_single", bus.empty, 1);
        check_eq("hold_tx_idle", tx, 1);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
